// File: rtl/ps2_scancode_rx_if.sv
// Pin, read-port and status bundle for the PS/2 scancode receiver.
// Read handshake: data_valid means rd_data holds the FIFO head; the head is consumed
// on any clock edge where rd_en=1 and data_valid=1, and rd_en while data_valid=0 is ignored.
interface ps2_scancode_rx_if #(
  parameter int DEPTH = 16
);
  logic                     ps2_clk;
  logic                     ps2_dat;
  logic                     rd_en;
  logic                     clr_err;
  logic [7:0]               rd_data;
  logic                     data_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     irq;
  logic                     parity_err;
  logic                     frame_err;
  logic                     overflow;
  logic [1:0]               fsm_state;

  modport slave (
    input  ps2_clk, ps2_dat, rd_en, clr_err,
    output rd_data, data_valid, count, irq, parity_err, frame_err, overflow, fsm_state
  );

  modport master (
    output ps2_clk, ps2_dat, rd_en, clr_err,
    input  rd_data, data_valid, count, irq, parity_err, frame_err, overflow, fsm_state
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// frame FSM with idle timeout, and a first-word-fall-through scancode FIFO.
module ps2_scancode_rx #(
  parameter int DEPTH          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic               clock,
  input  logic               reset,
  ps2_scancode_rx_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_prev_q, fall;
  logic [FW-1:0]          filt_cnt_q;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   push, set_perr, set_ferr;

  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic                   pop, full, do_push, drop;
  logic                   perr_q, ferr_q, ovf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat};
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // The filtered level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = '0;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s) begin
          state_d = S_DATA;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d[idx_q] = dat_s;
          if (idx_q == 3'd7) state_d = S_PARITY;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          push     = dat_s & (^{shift_q, par_q});
          set_perr = ~(^{shift_q, par_q});
          set_ferr = ~dat_s;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Mid-frame idle watchdog; any falling edge restarts it through the zero default.
    if (state_q != S_IDLE && !fall) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
        state_d  = S_IDLE;
        set_ferr = 1'b1;
        tmo_d    = '0;
      end
    end
  end

  assign pop     = bus.rd_en && (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      perr_q <= set_perr | (perr_q & ~bus.clr_err);
      ferr_q <= set_ferr | (ferr_q & ~bus.clr_err);
      ovf_q  <= drop     | (ovf_q  & ~bus.clr_err);
    end
  end

  // Head is gated so an empty FIFO presents 0x00 rather than stale or unwritten storage.
  assign bus.data_valid = (count_q != '0);
  assign bus.irq        = (count_q != '0);
  assign bus.rd_data    = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign bus.count      = count_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overflow   = ovf_q;
  assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomized scoreboard bench for ps2_scancode_rx: frame driver tasks, a queue model
// of the FIFO and sticky flags, and a monitor that checks every popped byte.
module tb_ps2_scancode_rx;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TMO   = 5000;
  localparam int H     = 20;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ps2_scancode_rx_if #(.DEPTH(DEPTH)) bus ();

  ps2_scancode_rx #(
    .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #10 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  bit exp_perr, exp_ferr, exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted read must deliver the oldest byte the model holds.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset && bus.rd_en) begin
        if (exp_q.size() != 0) begin
          check("data_valid_on_read", {31'd0, bus.data_valid}, 32'd1);
          if (bus.data_valid) begin
            e = exp_q.pop_front();
            check("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
          end
        end else if (bus.data_valid) begin
          check("unexpected_data", {31'd0, bus.data_valid}, 32'd0);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    bus.ps2_dat = b;
    cycles(H);
    bus.ps2_clk = 1'b0;
    cycles(H);
    bus.ps2_clk = 1'b1;
  endtask

  // pop_on_push raises rd_en for exactly the cycle in which the stop-bit edge
  // (after SYNC synchronizer and FILT filter cycles) turns into a push.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_on_push);
    logic [10:0] bits;
    logic par;
    par  = (~(^b)) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    bus.ps2_dat = bits[10];
    cycles(H);
    bus.ps2_clk = 1'b0;
    if (pop_on_push) begin
      cycles(SYNC + FILT);
      bus.rd_en = 1'b1;
      cycles(1);
      bus.rd_en = 1'b0;
      cycles(H - SYNC - FILT - 1);
    end else begin
      cycles(H);
    end
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    cycles(H);
    if (bad_par)  exp_perr = 1'b1;
    if (bad_stop) exp_ferr = 1'b1;
    if (!bad_par && !bad_stop) begin
      if (exp_q.size() < DEPTH || pop_on_push) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic read_one();
    bus.rd_en = 1'b1;
    cycles(1);
    bus.rd_en = 1'b0;
    cycles(1);
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    cycles(1);
    bus.clr_err = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    cycles(1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, {27'd0, bus.count}, exp_q.size());
    check({tag, "_valid"}, {31'd0, bus.data_valid}, {31'd0, exp_q.size() != 0});
    check({tag, "_irq"}, {31'd0, bus.irq}, {31'd0, exp_q.size() != 0});
    check({tag, "_parity_err"}, {31'd0, bus.parity_err}, {31'd0, exp_perr});
    check({tag, "_frame_err"}, {31'd0, bus.frame_err}, {31'd0, exp_ferr});
    check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    if (exp_q.size() != 0) check({tag, "_head"}, {24'd0, bus.rd_data}, {24'd0, exp_q[0]});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2 && bus.data_valid; i++) read_one();
    check({tag, "_drained"}, {31'd0, bus.data_valid}, 32'd0);
    check({tag, "_model_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, {27'd0, bus.count}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.data_valid}, 32'd0);
    check({tag, "_irq"}, {31'd0, bus.irq}, 32'd0);
    check({tag, "_rd_data"}, {24'd0, bus.rd_data}, 32'd0);
    check({tag, "_flags"}, {29'd0, bus.parity_err, bus.frame_err, bus.overflow}, 32'd0);
    check({tag, "_state"}, {30'd0, bus.fsm_state}, {30'd0, IDLE_CODE});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    reset = 1'b0;
    cycles(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    cycles(5);

    // single good frame, then one read
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check_status("valid_1c");
    read_one();
    check_status("valid_1c_read");

    // bad parity is flagged, dropped, and cleared by clr_err
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check_status("bad_parity");
    clear_err();
    check_status("bad_parity_clr");

    // 17 frames with no reads overflows the 16-entry FIFO
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check_status("overflow");
    drain("overflow");
    clear_err();

    // start + 4 data bits, then idle past the timeout
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    cycles(TMO - 200);
    check("timeout_not_yet", {31'd0, bus.fsm_state != IDLE_CODE}, 32'd1);
    cycles(300);
    exp_ferr = 1'b1;
    check("timeout_state", {30'd0, bus.fsm_state}, {30'd0, IDLE_CODE});
    check_status("timeout");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_status("after_timeout");
    drain("after_timeout");
    clear_err();

    // 2-cycle glitch with data low must not be taken as a start bit
    bus.ps2_dat = 1'b0;
    bus.ps2_clk = 1'b0;
    cycles(2);
    bus.ps2_clk = 1'b1;
    cycles(20);
    bus.ps2_dat = 1'b1;
    check("glitch_state", {30'd0, bus.fsm_state}, {30'd0, IDLE_CODE});
    check_status("glitch");

    // reset with a queued byte and a half-received frame
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    reset = 1'b0;
    cycles(2);
    check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    reset = 1'b1;
    cycles(5);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check_status("after_reset");
    drain("after_reset");

    // full FIFO with a pop on the push cycle: 0xAA must land at the tail
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    check_status("fill");
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    check_status("push_pop_full");
    check("tail_is_aa", {24'd0, exp_q[DEPTH-1]}, 32'h0000_00AA);
    drain("push_pop_full");

    // random frames with occasional parity/stop errors and random reads
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      send_frame(b, r == 0, r == 1, 1'b0);
      check_status("random");
      if ($urandom_range(0, 1) == 1) read_one();
    end
    drain("random");
    clear_err();
    check_status("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
